// File: rtl/pad_host_if.sv
// Host-side initiator for the PAD_fsm point-multiplication core: loads k word-serially,
// runs the start/finish handshake, measures latency and streams the four results back out.
module pad_host_if #(
  parameter int unsigned DATA_LEN = 256,
  parameter int unsigned BUS_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BUS_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUS_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic [31:0]         latency,
  output logic                pad_start,
  output logic [DATA_LEN-1:0] pad_k,
  input  logic                pad_finish,
  input  logic [DATA_LEN-1:0] pad_x3,
  input  logic [DATA_LEN-1:0] pad_z31,
  input  logic [DATA_LEN-1:0] pad_y3,
  input  logic [DATA_LEN-1:0] pad_z32
);

  localparam int unsigned NW    = DATA_LEN / BUS_W;
  localparam int unsigned NR    = 4 * NW;
  localparam int unsigned CW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned IW    = $clog2(NR);
  localparam int unsigned LAT_W = 32;

  if (DATA_LEN % BUS_W != 0) begin : g_bad_width
    $error("DATA_LEN must be a multiple of BUS_W");
  end

  typedef enum logic [2:0] {LOAD, START, RUN, SEND, DRAIN} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [IW-1:0]               idx;
  logic [IW-1:0]               idx_nxt;
  logic [LAT_W-1:0]            lat_cnt;
  logic [LAT_W-1:0]            lat_inc;
  logic [NW-1:0][BUS_W-1:0]    k_q;
  logic [NR-1:0][BUS_W-1:0]    res_q;

  assign pad_k   = k_q;
  assign idx_nxt = idx + IW'(1);
  // Saturating increment shared by the running counter and the captured latency.
  assign lat_inc = (lat_cnt == '1) ? lat_cnt : lat_cnt + LAT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      cnt       <= '0;
      idx       <= '0;
      lat_cnt   <= '0;
      k_q       <= '0;
      res_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      latency   <= '0;
      pad_start <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            k_q[cnt] <= in_data;
            if (cnt == CW'(NW - 1)) begin
              cnt      <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= START;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        // A finish still high from the previous job must fall before we start.
        START: begin
          if (!pad_finish) begin
            pad_start <= 1'b1;
            lat_cnt   <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (pad_finish) begin
            res_q     <= {pad_z32, pad_y3, pad_z31, pad_x3};
            latency   <= lat_inc;
            pad_start <= 1'b0;
            idx       <= '0;
            out_data  <= pad_x3[BUS_W-1:0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= SEND;
          end else begin
            lat_cnt <= lat_inc;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx == IW'(NR - 1)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= DRAIN;
            end else begin
              idx      <= idx_nxt;
              out_data <= res_q[idx_nxt];
              out_last <= (idx_nxt == IW'(NR - 1));
            end
          end
        end
        DRAIN: begin
          if (!pad_finish) begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pad_host_if.sv
// Directed bench for pad_host_if: load/start/run/send/drain flow, stalls, stale finish,
// mid-run reset and latency saturation.
module tb_pad_host_if;

  localparam int unsigned DATA_LEN = 256;
  localparam int unsigned BUS_W    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [BUS_W-1:0]    in_data;
  logic                out_valid;
  logic                out_ready;
  logic [BUS_W-1:0]    out_data;
  logic                out_last;
  logic                busy;
  logic [31:0]         latency;
  logic                pad_start;
  logic [DATA_LEN-1:0] pad_k;
  logic                pad_finish;
  logic [DATA_LEN-1:0] pad_x3, pad_z31, pad_y3, pad_z32;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_LEN-1:0] X3  = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
  localparam logic [DATA_LEN-1:0] Z31 = {DATA_LEN{1'b1}};
  localparam logic [DATA_LEN-1:0] Y3  = {32{8'hA5}};
  localparam logic [DATA_LEN-1:0] Z32 = '0;
  localparam logic [DATA_LEN-1:0] K2  = 256'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
  localparam logic [DATA_LEN-1:0] K3  = 256'h54a831eb_0f3c2d19_8e7a6b5c_4d3e2f10_a1b2c3d4_e5f60718_293a4b5c_6d7e1c70;

  pad_host_if #(.DATA_LEN(DATA_LEN), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .latency(latency),
    .pad_start(pad_start), .pad_k(pad_k), .pad_finish(pad_finish),
    .pad_x3(pad_x3), .pad_z31(pad_z31), .pad_y3(pad_y3), .pad_z32(pad_z32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_LEN-1:0] obs, input logic [DATA_LEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [BUS_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_k(input logic [DATA_LEN-1:0] k);
    logic [DATA_LEN-1:0] kv;
    kv = k;
    for (int i = 0; i < 8; i++) beat(kv[32*i +: 32]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4*DATA_LEN-1:0] exp_res;
    logic [15:0]           pat;
    int                    idx;
    int                    cyc;

    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; pad_finish = 1'b0;
    pad_x3 = '0; pad_z31 = '0; pad_y3 = '0; pad_z32 = '0;
    tick(); tick();
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_pad_start", pad_start, 0);
    check("rst_busy",      busy,      0);
    check("rst_latency",   latency,   0);
    check("rst_pad_k",     pad_k,     0);
    check("rst_out_data",  out_data,  0);
    rst = 1'b1;
    tick();

    // Job 1: k = 20, core finishes 100 cycles after start
    load_k(256'd20);
    check("j1_pad_k",       pad_k,     256'h14);
    check("j1_busy",        busy,      1);
    check("j1_in_ready",    in_ready,  0);
    check("j1_start_early", pad_start, 0);
    tick();
    check("j1_start", pad_start, 1);
    repeat (100) @(posedge clk);
    #1;
    pad_finish = 1'b1;
    pad_x3 = X3; pad_z31 = Z31; pad_y3 = Y3; pad_z32 = Z32;
    tick();
    pad_x3 = '1; pad_z31 = '0; pad_y3 = '0; pad_z32 = '1;
    check("j1_latency",     latency,   101);
    check("j1_start_drop",  pad_start, 0);
    check("j1_out_valid",   out_valid, 1);

    // Stream out with stalls
    exp_res = {Z32, Y3, Z31, X3};
    pat = 16'b1001_1101_1001_0111;
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 200) begin
      out_ready = pat[cyc % 16];
      check($sformatf("w%0d_valid", idx), out_valid, 1);
      check($sformatf("w%0d_data", idx),  out_data, exp_res[32*idx +: 32]);
      check($sformatf("w%0d_last", idx),  out_last, (idx == 31) ? 1 : 0);
      if (out_ready) idx++;
      cyc++;
      tick();
    end
    out_ready = 1'b0;
    check("stream_words", idx, 32);
    check("drain_out_valid", out_valid, 0);
    check("drain_busy",      busy,      1);
    repeat (3) tick();
    check("drain_hold", in_ready, 0);
    pad_finish = 1'b0;
    tick();
    check("drain_exit_ready", in_ready, 1);
    check("drain_exit_busy",  busy,     0);

    // Job 2: finish rises during LOAD and is still high at START
    pad_finish = 1'b1;
    load_k(K2);
    check("j2_pad_k", pad_k, K2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("j2_stale%0d", i), pad_start, 0);
      tick();
    end
    check("j2_no_capture", out_valid, 0);
    pad_finish = 1'b0;
    tick();
    check("j2_start", pad_start, 1);
    tick(); tick();
    #3 rst = 1'b0;
    #1;
    check("mid_rst_start",    pad_start, 0);
    check("mid_rst_ready",    in_ready,  1);
    check("mid_rst_busy",     busy,      0);
    check("mid_rst_pad_k",    pad_k,     0);
    check("mid_rst_latency",  latency,   0);
    tick();
    rst = 1'b1;
    tick();

    // Partial load discarded by reset, then fresh load of K3
    beat(32'hdead_0001); beat(32'hdead_0002); beat(32'hdead_0003);
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    load_k(K3);
    check("j3_pad_k", pad_k, K3);
    tick();
    check("j3_start", pad_start, 1);

    // Latency saturation with the counter forced near its maximum
    force dut.lat_cnt = 32'hFFFF_FFFC;
    tick();
    release dut.lat_cnt;
    repeat (6) tick();
    check("sat_counter", dut.lat_cnt, 32'hFFFF_FFFF);
    pad_finish = 1'b1;
    pad_x3 = 256'h0123_4567;
    tick();
    check("sat_latency", latency,   32'hFFFF_FFFF);
    check("j3_word0",    out_data,  32'h0123_4567);
    check("j3_k_held",   pad_k,     K3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
